// File: rtl/mem_arbiter_if.sv
// Bus between the pipeline requesters (IF stage, EX/MEM latch), the memory
// arbiter and the single-ported RAM model.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // instruction-fetch requester
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              ihit;
    logic [DATA_W-1:0] iload;
    // data requester
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dhit;
    logic [DATA_W-1:0] dload;
    // RAM side
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic              ram_ready;
    // arbiter status
    logic              busy;

    // arbiter view
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
        output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, busy
    );

    // pipeline + RAM model view
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
        input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Memory arbiter: shares one single-ported RAM between instruction fetch and
// data accesses. Data wins by default; after STARVE_MAX back-to-back data
// grants with a fetch waiting, the fetch is forced through next.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } state_t;

    state_t     state_q;
    logic [3:0] starve_q;

    logic dreq;
    logic at_max;

    logic              ramREN_c;
    logic              ramWEN_c;
    logic [ADDR_W-1:0] ramaddr_c;
    logic [DATA_W-1:0] ramstore_c;
    logic              ihit_c;
    logic              dhit_c;
    logic [DATA_W-1:0] iload_c;
    logic [DATA_W-1:0] dload_c;

    assign dreq   = bus.dREN | bus.dWEN;
    assign at_max = (starve_q == STARVE_LIM);

    // Grant sequencing and starvation accounting; every access returns to
    // IDLE so there is always one bubble cycle between grants.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            starve_q <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dreq && !(bus.iREN && at_max))
                        state_q <= DGRANT;
                    else if (bus.iREN)
                        state_q <= IGRANT;
                end
                DGRANT: begin
                    if (!dreq) begin
                        // requester withdrew: abandon, counter untouched
                        state_q <= IDLE;
                    end else if (bus.ram_ready) begin
                        state_q <= IDLE;
                        if (!bus.iREN)
                            starve_q <= 4'd0;
                        else if (!at_max)
                            starve_q <= starve_q + 4'd1;
                    end
                end
                IGRANT: begin
                    if (!bus.iREN) begin
                        state_q <= IDLE;
                    end else if (bus.ram_ready) begin
                        state_q  <= IDLE;
                        starve_q <= 4'd0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // RAM drive and hit/load generation; enables follow the live request so
    // an abort drops them in the same cycle.
    always_comb begin
        ramREN_c   = 1'b0;
        ramWEN_c   = 1'b0;
        ramaddr_c  = '0;
        ramstore_c = '0;
        ihit_c     = 1'b0;
        dhit_c     = 1'b0;
        iload_c    = '0;
        dload_c    = '0;
        case (state_q)
            DGRANT: begin
                ramaddr_c = bus.daddr;
                if (bus.dWEN) begin
                    ramWEN_c   = 1'b1;
                    ramstore_c = bus.dstore;
                end else if (bus.dREN) begin
                    ramREN_c = 1'b1;
                end
                dhit_c = dreq & bus.ram_ready;
                if (dhit_c && !bus.dWEN)
                    dload_c = bus.ramload;
            end
            IGRANT: begin
                ramaddr_c = bus.iaddr;
                ramREN_c  = bus.iREN;
                ihit_c    = bus.iREN & bus.ram_ready;
                if (ihit_c)
                    iload_c = bus.ramload;
            end
            default: ;
        endcase
    end

    assign bus.ramREN   = ramREN_c;
    assign bus.ramWEN   = ramWEN_c;
    assign bus.ramaddr  = ramaddr_c;
    assign bus.ramstore = ramstore_c;
    assign bus.ihit     = ihit_c;
    assign bus.dhit     = dhit_c;
    assign bus.iload    = iload_c;
    assign bus.dload    = dload_c;
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported main memory between the instruction-fetch requester and the data requester. The data requester is the EX/MEM latch side, which stalls on a missing dhit.
- Sits between the pipeline (IF stage and EX/MEM latch) and the RAM model.
- Sequences each access through a small FSM and returns ihit/dhit plus load data.
- Data has priority, with a starvation guard so fetch progresses under continuous data traffic.

Parameters:
- ADDR_W, 32, address width of both requesters and RAM.
- DATA_W, 32, word width.
- STARVE_MAX, 4, consecutive data grants allowed while iREN is pending before fetch is forced next (legal range 1..15).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- iREN  in  1  instruction read request; level, held until ihit.
- iaddr  in  ADDR_W  instruction address.
- dREN  in  1  data read request; level, held until dhit.
- dWEN  in  1  data write request; level, held until dhit.
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  data write value.
- ramload  in  DATA_W  RAM read data, valid when ram_ready=1.
- ram_ready  in  1  RAM completes the current access this cycle.
- ihit  out  1  fetch complete this cycle.
- dhit  out  1  data access complete this cycle.
- iload  out  DATA_W  instruction word; ramload when ihit, else 0.
- dload  out  DATA_W  load data; ramload when dhit and read, else 0.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- busy  out  1  FSM not in IDLE.

Behaviour:
- States: IDLE, DGRANT, IGRANT. State register and starve counter (4 bits) are the only flops.
- Reset (RST=1, asynchronous, also mid-access):
  - State goes to IDLE and starve_cnt to 0 immediately.
  - All outputs are 0 while reset is asserted: ramREN, ramWEN, ramaddr, ramstore, ihit, dhit, iload, dload, busy.
  - An in-flight access is abandoned; no hit is produced for it.
- IDLE:
  - No RAM enables; ramaddr and ramstore are 0.
  - dreq = dREN|dWEN.
  - If dreq and not (iREN and starve_cnt==STARVE_MAX), go to DGRANT.
  - Else if iREN, go to IGRANT.
  - Else stay in IDLE.
- DGRANT:
  - ramaddr=daddr.
  - dWEN=1 drives ramWEN=1 and ramstore=dstore; dWEN has precedence if dREN and dWEN are both high.
  - Otherwise ramREN=1.
  - dhit = ram_ready (combinational). On ram_ready, go to IDLE next edge.
  - starve_cnt: +1 (saturating at STARVE_MAX) if iREN=1 at completion, else cleared.
- IGRANT:
  - ramREN=1, ramaddr=iaddr.
  - ihit = ram_ready. On ram_ready, go to IDLE and clear starve_cnt.
- Abort: if the granted requester deasserts its request(s) before ram_ready, drop the RAM enables that same cycle (combinational from the request). Go to IDLE next edge with no hit and no change to starve_cnt.
- Latency:
  - A request seen in IDLE at edge N is granted during cycle N+1.
  - With ram_ready high on the first grant cycle, the hit appears in cycle N+1.
  - Minimum 2 cycles between successive accesses; the IDLE bubble is mandatory.
- Exclusivity: ihit and dhit are never high together. ramREN and ramWEN are never high together.
- Changing daddr, iaddr or dstore during a grant passes straight through to the RAM; requesters must hold them stable.

Test Plan:
- Reset and idle: RST pulse, all requests 0 -> all outputs 0, busy 0. Assert RST mid-IGRANT -> ramREN drops asynchronously, no ihit.
- Single fetch, ram_ready tied 1: iREN=1, iaddr=0x40, ramload=0x8C220004 -> IGRANT next cycle, ramaddr=0x40, ihit=1, iload=0x8C220004 in that cycle.
- Simultaneous iREN and dREN, addrs 0x100 and 0x200, ram_ready after 2 wait cycles -> data served first (dhit on the third grant cycle, dload=ramload), then IDLE, then IGRANT at 0x100.
- Write precedence: dREN=dWEN=1, daddr=0x300, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF, dload=0 on dhit.
- Starvation: iREN held, dREN re-asserted continuously, STARVE_MAX=4 -> exactly 4 dhits, then an IGRANT with ihit, then the data grant resumes; starve_cnt back to 0.
- Abort: DGRANT with ram_ready low, drop dREN -> ramREN 0 same cycle, IDLE next cycle, dhit never asserted, pending iREN granted next.
